register_pipe_en: RTL and testbench

REGISTER_PIPE_EN -- requirements
Module: register_pipe_en

---
 rtl/register_pkg.sv | 18 +
 rtl/register_en_n.sv | 34 +++
 rtl/register_pipe_en.sv | 70 +++++++
 tb/tb_register_pipe_en.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_pkg
// Description : Shared defaults and sizing helper for the enabled register pipe.
// Revision    : 1.0
// ============================================================================
package register_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 4;

    // Width needed to hold a population count of 0..depth valid stages.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : register_pkg
`default_nettype wire

// File: rtl/register_en_n.sv
`default_nettype none
// ============================================================================
// Module      : register_en_n
// Description : N-bit enabled register; the MSB is a flag with its own clear.
// Revision    : 1.0
// ============================================================================
module register_en_n #(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear drops only the flag bit; the payload bits keep their value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q[WIDTH-1] <= 1'b0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : register_en_n
`default_nettype wire

// File: rtl/register_pipe_en.sv
`default_nettype none
// ============================================================================
// Module      : register_pipe_en
// Description : DEPTH-stage enabled data pipeline with per-stage valid flags,
//               flush, and live occupancy count.
// Revision    : 1.0
// ============================================================================
module register_pipe_en
    import register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW   = count_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    // Each stage word is {valid, data}.
    logic [WIDTH:0]   w_stage_d [DEPTH];
    logic [WIDTH:0]   w_stage_q [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [CW-1:0]    w_count;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_stage_d[k] = {i_valid, i_d};
        end else begin : g_body
            assign w_stage_d[k] = w_stage_q[k-1];
        end

        register_en_n #(
            .WIDTH (WIDTH + 1)
        ) u_stage (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (i_en),
            .i_clr (i_flush),
            .i_d   (w_stage_d[k]),
            .o_q   (w_stage_q[k])
        );

        assign w_valid[k] = w_stage_q[k][WIDTH];
    end

    // Population count of the valid flags; cannot exceed DEPTH by construction.
    always_comb begin
        w_count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_count = w_count + CW'(w_valid[k]);
        end
    end

    assign o_q     = w_stage_q[DEPTH-1][WIDTH-1:0];
    assign o_valid = w_valid[DEPTH-1];
    assign o_count = w_count;
    assign o_full  = (w_count == CW'(DEPTH));
    assign o_empty = (w_count == '0);

endmodule : register_pipe_en
`default_nettype wire

// File: tb/tb_register_pipe_en.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_pipe_en
// Description : Directed vector table plus randomized run against a queue model.
// Revision    : 1.0
// ============================================================================
module tb_register_pipe_en;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int NVEC  = 25;
    localparam int NRAND = 400;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    register_pipe_en #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_flush (flush),
        .i_valid (valid),
        .i_d     (d),
        .o_q     (q),
        .o_valid (q_valid),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

    always #5 clk = ~clk;

    // ctl = {rst, en, flush, valid}
    typedef struct packed {
        logic [3:0]       ctl;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] eq;
        logic             ev;
        logic [CW-1:0]    ec;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [3:0] ctl, input logic [3:0] dd,
                                input logic [3:0] eq, input logic ev,
                                input logic [1:0] ec);
        vec_t v;
        v.ctl = ctl;
        v.d   = dd;
        v.eq  = eq;
        v.ev  = ev;
        v.ec  = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] eq, input logic ev,
                                 input int ec);
        check({tag, " q"},     32'(q),       32'(eq));
        check({tag, " valid"}, 32'(q_valid), 32'(ev));
        check({tag, " count"}, 32'(count),   32'(ec));
        check({tag, " full"},  32'(full),    32'(ec == DEPTH));
        check({tag, " empty"}, 32'(empty),   32'(ec == 0));
    endtask

    task automatic step(input logic r, input logic e, input logic f,
                        input logic v, input logic [WIDTH-1:0] dd);
        rst   = r;
        en    = e;
        flush = f;
        valid = v;
        d     = dd;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the pipe as a list of {valid, data} words, newest first.
    logic [WIDTH:0] model [$];

    task automatic model_edge(input logic r, input logic e, input logic f,
                              input logic v, input logic [WIDTH-1:0] dd);
        if (r) begin
            foreach (model[i]) model[i] = '0;
        end else if (f) begin
            foreach (model[i]) model[i][WIDTH] = 1'b0;
        end else if (e) begin
            model.push_front({v, dd});
            void'(model.pop_back());
        end
    endtask

    function automatic int model_count();
        int n = 0;
        foreach (model[i]) n += int'(model[i][WIDTH]);
        return n;
    endfunction

    initial begin
        // Reset, idle, fill, hold, mixed validity, flush, reset mid-stream, restart.
        vecs[0]  = mk(4'b1000, 4'h0, 4'h0, 1'b0, 2'd0);
        vecs[1]  = mk(4'b0001, 4'h7, 4'h0, 1'b0, 2'd0);
        vecs[2]  = mk(4'b0001, 4'h7, 4'h0, 1'b0, 2'd0);
        vecs[3]  = mk(4'b0001, 4'h7, 4'h0, 1'b0, 2'd0);
        vecs[4]  = mk(4'b0101, 4'hA, 4'h0, 1'b0, 2'd1);
        vecs[5]  = mk(4'b0101, 4'h5, 4'h0, 1'b0, 2'd2);
        vecs[6]  = mk(4'b0101, 4'hF, 4'hA, 1'b1, 2'd3);
        vecs[7]  = mk(4'b0101, 4'h0, 4'h5, 1'b1, 2'd3);
        vecs[8]  = mk(4'b0001, 4'hC, 4'h5, 1'b1, 2'd3);
        vecs[9]  = mk(4'b0001, 4'hC, 4'h5, 1'b1, 2'd3);
        vecs[10] = mk(4'b0001, 4'hC, 4'h5, 1'b1, 2'd3);
        vecs[11] = mk(4'b0001, 4'hC, 4'h5, 1'b1, 2'd3);
        vecs[12] = mk(4'b0101, 4'h1, 4'hF, 1'b1, 2'd3);
        vecs[13] = mk(4'b0100, 4'h2, 4'h0, 1'b1, 2'd2);
        vecs[14] = mk(4'b0101, 4'h3, 4'h1, 1'b1, 2'd2);
        vecs[15] = mk(4'b0101, 4'h4, 4'h2, 1'b0, 2'd2);
        vecs[16] = mk(4'b0101, 4'h5, 4'h3, 1'b1, 2'd3);
        vecs[17] = mk(4'b0111, 4'h6, 4'h3, 1'b0, 2'd0);
        vecs[18] = mk(4'b0101, 4'h7, 4'h4, 1'b0, 2'd1);
        vecs[19] = mk(4'b0101, 4'h8, 4'h5, 1'b0, 2'd2);
        vecs[20] = mk(4'b1111, 4'h9, 4'h0, 1'b0, 2'd0);
        vecs[21] = mk(4'b0101, 4'hB, 4'h0, 1'b0, 2'd1);
        vecs[22] = mk(4'b0001, 4'h6, 4'h0, 1'b0, 2'd1);
        vecs[23] = mk(4'b0100, 4'hD, 4'h0, 1'b0, 2'd1);
        vecs[24] = mk(4'b0101, 4'hE, 4'hB, 1'b1, 2'd2);

        @(posedge clk);
        #1;
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].ctl[3], vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].d);
            check_outputs($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ev, int'(vecs[i].ec));
        end

        // Randomized run against the list model.
        model.delete();
        for (int i = 0; i < DEPTH; i++) model.push_back('0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check_outputs("rand_reset", 4'h0, 1'b0, 0);
        for (int n = 0; n < NRAND; n++) begin
            logic r, e, f, v;
            logic [WIDTH-1:0] dd;
            r  = ($urandom_range(0, 39) == 0);
            f  = ($urandom_range(0, 15) == 0);
            e  = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 2) != 0);
            dd = WIDTH'($urandom);
            model_edge(r, e, f, v, dd);
            step(r, e, f, v, dd);
            check_outputs($sformatf("rand%0d", n), model[DEPTH-1][WIDTH-1:0],
                          model[DEPTH-1][WIDTH], model_count());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_pipe_en
`default_nettype wire
